two_level_branch_predictor: RTL

- Parametrised local-history two-level branch predictor (BHT of per-branch histories indexing a PHT of saturating counters).
- Successor to the fixed 10-bit/2-bit predictor.
- Adds configurable depth, history length and counter width, a hardware table-initialisation sweep, registered prediction with a valid flag, and a defined same-cycle lookup/update rule.
- Sits in fetch stage 1; updates arrive from branch resolution in execute.

---
 rtl/bp_pkg.sv | 49 ++++
 rtl/bp_sat_ctr.sv | 14 +
 rtl/two_level_branch_predictor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the two-level local-history branch predictor: state encoding,
// counter encodings and the index-fold / saturating-step helpers.
package bp_pkg;

   typedef enum logic [0:0] {
      StInit,
      StRun
   } bp_state_e;

   // Named encodings for the common 2-bit counter case.
   localparam logic [1:0] CtrStrongNt = 2'b00;
   localparam logic [1:0] CtrWeakNt   = 2'b01;
   localparam logic [1:0] CtrWeakT    = 2'b10;
   localparam logic [1:0] CtrStrongT  = 2'b11;

   // All-ones mask of the given width, clamped to 32 bits.
   function automatic logic [31:0] low_mask(input int unsigned width);
      if (width >= 32) begin
         return '1;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

   // Saturating counter step on a zero-extended counter of ctr_w bits.
   function automatic logic [31:0] sat_step(input logic [31:0] ctr,
                                            input int unsigned ctr_w,
                                            input logic taken);
      logic [31:0] max_v;
      max_v = low_mask(ctr_w);
      if (taken) begin
         return (ctr >= max_v) ? max_v : ctr + 32'd1;
      end
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
   endfunction

   // Low idx_w history bits; shorter histories arrive zero-extended, so masking covers both cases.
   function automatic logic [31:0] fold_hist(input logic [31:0] hist, input int unsigned idx_w);
      return hist & low_mask(idx_w);
   endfunction

   // Weakly-taken reset value: only the counter MSB set.
   function automatic logic [31:0] ctr_init(input int unsigned ctr_w);
      if (ctr_w == 2) begin
         return {30'd0, CtrWeakT};
      end
      return 32'd1 << (ctr_w - 1);
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-state of a CTR_W-bit saturating up/down counter.
module bp_sat_ctr
   import bp_pkg::*;
#(
   parameter int unsigned CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next
);

   assign ctr_next = CTR_W'(sat_step(32'(ctr), CTR_W, taken));

endmodule

// File: rtl/two_level_branch_predictor.sv
// Local-history two-level branch predictor: per-branch BHT indexes a PHT of saturating counters.
// Define BP_STATS_EN to add lookup / mispredict statistics counters and the upd_mispred input.
module two_level_branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned IDX_W  = 10,
   parameter int unsigned HIST_W = 10,
   parameter int unsigned CTR_W  = 2,
   parameter int unsigned PC_LSB = 2
) (
   input  logic              clk,
   input  logic              resetn,
   output logic              ready,
   input  logic              lookup_valid,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_hist,
   input  logic              upd_en,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [HIST_W-1:0] upd_hist,
   input  logic              upd_taken
`ifdef BP_STATS_EN
   ,
   input  logic              upd_mispred,
   output logic [31:0]       stat_lookups,
   output logic [31:0]       stat_mispred
`endif
);

   localparam int unsigned Entries = 2 ** IDX_W;
   localparam logic [CTR_W-1:0] CtrInit = CTR_W'(ctr_init(CTR_W));

   if (HIST_W < 1 || HIST_W > 32 || CTR_W < 1 || CTR_W > 32 || PC_LSB + IDX_W > PC_W) begin : g_param_check
      $error("two_level_branch_predictor: unsupported parameter combination");
   end

   logic [HIST_W-1:0] bht_q [Entries];
   logic [CTR_W-1:0]  pht_q [Entries];

   bp_state_e        state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;

   logic              pred_valid_q;
   logic              pred_taken_q;
   logic [HIST_W-1:0] pred_hist_q;

   logic run_lookup;
   logic run_upd;

   logic [IDX_W-1:0]  lk_bidx;
   logic [HIST_W-1:0] lk_hist;
   logic [IDX_W-1:0]  lk_pidx;
   logic              lk_taken;

   logic [IDX_W-1:0]  upd_bidx;
   logic [IDX_W-1:0]  upd_pidx;
   logic [HIST_W-1:0] upd_bht_old;
   logic [HIST_W-1:0] upd_bht_new;
   logic [CTR_W-1:0]  upd_ctr_old;
   logic [CTR_W-1:0]  upd_ctr_new;

   // Only the index window of each PC is used.
   logic unused_pc;
   assign unused_pc = ^{lookup_pc, upd_pc};

   // ---------------------------------------------------------------------------------------------
   // Init sweep / run FSM
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         StInit: begin
            sweep_d = sweep_q + IDX_W'(1);
            if (sweep_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            state_d = StRun;
         end
         default: begin
            state_d = StInit;
            sweep_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StInit;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   assign ready      = (state_q == StRun);
   assign run_lookup = ready & lookup_valid;
   assign run_upd    = ready & upd_en;

   // ---------------------------------------------------------------------------------------------
   // Lookup path: BHT read feeds the PHT index in the same cycle, result is registered
   // ---------------------------------------------------------------------------------------------
   assign lk_bidx  = lookup_pc[PC_LSB +: IDX_W];
   assign lk_hist  = bht_q[lk_bidx];
   assign lk_pidx  = IDX_W'(fold_hist(32'(lk_hist), IDX_W)) ^ lk_bidx;
   assign lk_taken = pht_q[lk_pidx][CTR_W-1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_hist_q  <= '0;
      end else begin
         pred_valid_q <= run_lookup;
         if (run_lookup) begin
            pred_taken_q <= lk_taken;
            pred_hist_q  <= lk_hist;
         end
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_hist  = pred_hist_q;

   // ---------------------------------------------------------------------------------------------
   // Update path: PHT is indexed with the history carried with the branch, not the live BHT
   // ---------------------------------------------------------------------------------------------
   assign upd_bidx    = upd_pc[PC_LSB +: IDX_W];
   assign upd_pidx    = IDX_W'(fold_hist(32'(upd_hist), IDX_W)) ^ upd_bidx;
   assign upd_bht_old = bht_q[upd_bidx];
   assign upd_ctr_old = pht_q[upd_pidx];

   if (HIST_W == 1) begin : g_hist_one
      logic unused_bht_old;
      assign unused_bht_old = upd_bht_old[0];
      assign upd_bht_new    = upd_taken;
   end else begin : g_hist_shift
      logic unused_bht_old;
      assign unused_bht_old = upd_bht_old[HIST_W-1];
      assign upd_bht_new    = {upd_bht_old[HIST_W-2:0], upd_taken};
   end

   bp_sat_ctr #(
      .CTR_W    (CTR_W)
   ) u_sat_ctr (
      .ctr      (upd_ctr_old),
      .taken    (upd_taken),
      .ctr_next (upd_ctr_new)
   );

   // Tables have no reset; the sweep initialises them one entry per cycle.
   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         bht_q[sweep_q] <= '0;
         pht_q[sweep_q] <= CtrInit;
      end else if (run_upd) begin
         bht_q[upd_bidx] <= upd_bht_new;
         pht_q[upd_pidx] <= upd_ctr_new;
      end
   end

`ifdef BP_STATS_EN
   // ---------------------------------------------------------------------------------------------
   // Saturating statistics counters
   // ---------------------------------------------------------------------------------------------
   logic [31:0] stat_lookups_q;
   logic [31:0] stat_mispred_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_lookups_q <= '0;
         stat_mispred_q <= '0;
      end else begin
         if (run_lookup && stat_lookups_q != '1) begin
            stat_lookups_q <= stat_lookups_q + 32'd1;
         end
         if (run_upd && upd_mispred && stat_mispred_q != '1) begin
            stat_mispred_q <= stat_mispred_q + 32'd1;
         end
      end
   end

   assign stat_lookups = stat_lookups_q;
   assign stat_mispred = stat_mispred_q;
`endif

endmodule
